ifetch_ctrl: RTL and testbench

//   Fetch stage: owns the PC, drives the instruction bus with a req/ack handshake and

---
 rtl/ifetch_ctrl_pkg.sv | 18 +
 rtl/ifetch_ctrl_if_id.sv | 60 ++++++
 rtl/ifetch_ctrl.sv | 145 ++++++++++++++
 tb/tb_ifetch_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_ctrl_pkg.sv
// Shared definitions for the fetch stage: bubble instruction, FSM encodings
// and the word-alignment helper used on redirect targets.
package ifetch_ctrl_pkg;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH   = 2'd1,
        S_DISCARD = 2'd2,
        S_STALL   = 2'd3
    } fetch_state_e;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_ctrl_if_id.sv
// IF/ID pipeline register. Flush inserts a bubble; hold freezes the contents.
// Otherwise every edge either loads a new instruction or consumes the current
// one, leaving a bubble, so decode never sees the same instruction twice.
module ifetch_ctrl_if_id #(
    parameter logic [31:0] NOP_INS = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        hold_i,
    input  logic        load_i,
    input  logic [31:0] ins_i,
    input  logic [31:0] ins_addr_i,
    output logic [31:0] ins_o,
    output logic [31:0] ins_addr_o,
    output logic        ins_valid_o
);

    logic [31:0] ins_q, ins_d;
    logic [31:0] addr_q, addr_d;
    logic        valid_q, valid_d;

    // Next-value selection: flush beats hold, hold beats load/consume.
    always_comb begin
        ins_d   = ins_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        if (flush_i) begin
            ins_d   = NOP_INS;
            valid_d = 1'b0;
        end else if (!hold_i) begin
            if (load_i) begin
                ins_d   = ins_i;
                addr_d  = ins_addr_i;
                valid_d = 1'b1;
            end else begin
                ins_d   = NOP_INS;
                valid_d = 1'b0;
            end
        end
    end

    // Register with asynchronous reset to a bubble at address zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ins_q   <= NOP_INS;
            addr_q  <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            ins_q   <= ins_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
        end
    end

    assign ins_o       = ins_q;
    assign ins_addr_o  = addr_q;
    assign ins_valid_o = valid_q;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch stage controller: owns the PC, runs the req/ack instruction bus,
// absorbs redirects and stalls from execute, and feeds the IF/ID register.
// While a redirected fetch is still outstanding, pc_q already holds the new
// target and serves as the saved redirect; ibus_addr_o stays on the stale
// address until the bus acks it.
module ifetch_ctrl
    import ifetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INS    = INST_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_ack_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] ins_o,
    output logic [31:0] ins_addr_o,
    output logic        ins_valid_o,
    output logic [31:0] pc_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         out_q, out_d;          // request was up last cycle and not acked
    logic         buf_valid_q, buf_valid_d;
    logic [31:0]  buf_ins_q, buf_addr_q;
    logic         buf_wr;
    logic         req;
    logic         ifid_flush, ifid_hold, ifid_load;
    logic [31:0]  ld_ins, ld_addr;

    // Next-state, PC, buffer and IF/ID control; jump takes priority over all else.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_valid_d = buf_valid_q;
        buf_wr      = 1'b0;
        ifid_flush  = 1'b0;
        ifid_hold   = hold_flag_i;
        ifid_load   = 1'b0;
        ld_ins      = ibus_rdata_i;
        ld_addr     = addr_q;

        // A fresh request is suppressed under hold; an outstanding one must stay up.
        case (state_q)
            S_FETCH:   req = out_q | ~hold_flag_i;
            S_DISCARD: req = 1'b1;
            default:   req = 1'b0;
        endcase

        if (jump_en_i) begin
            pc_d        = align_word(jump_addr_i);
            ifid_flush  = 1'b1;
            buf_valid_d = 1'b0;
            state_d     = (req && !ibus_ack_i) ? S_DISCARD : S_FETCH;
        end else begin
            case (state_q)
                S_IDLE: state_d = S_FETCH;
                S_FETCH: begin
                    if (!req) begin
                        state_d = S_STALL;
                    end else if (ibus_ack_i) begin
                        pc_d = pc_q + 32'd4;
                        if (hold_flag_i) begin
                            buf_wr      = 1'b1;
                            buf_valid_d = 1'b1;
                            state_d     = S_STALL;
                        end else begin
                            ifid_load = 1'b1;
                        end
                    end
                end
                S_DISCARD: begin
                    if (ibus_ack_i) state_d = S_FETCH;
                end
                S_STALL: begin
                    if (!hold_flag_i) begin
                        state_d = S_FETCH;
                        if (buf_valid_q) begin
                            ifid_load   = 1'b1;
                            ld_ins      = buf_ins_q;
                            ld_addr     = buf_addr_q;
                            buf_valid_d = 1'b0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        out_d  = req & ~ibus_ack_i;
        addr_d = (state_d == S_DISCARD) ? addr_q : pc_d;
    end

    // Control and address state, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_ADDR;
            addr_q      <= RESET_ADDR;
            out_q       <= 1'b0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            out_q       <= out_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    // Skid-buffer payload; meaningful only while buf_valid_q is set.
    always_ff @(posedge clk) begin
        if (buf_wr) begin
            buf_ins_q  <= ibus_rdata_i;
            buf_addr_q <= addr_q;
        end
    end

    ifetch_ctrl_if_id #(
        .NOP_INS(NOP_INS)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .flush_i    (ifid_flush),
        .hold_i     (ifid_hold),
        .load_i     (ifid_load),
        .ins_i      (ld_ins),
        .ins_addr_i (ld_addr),
        .ins_o      (ins_o),
        .ins_addr_o (ins_addr_o),
        .ins_valid_o(ins_valid_o)
    );

    assign ibus_req_o  = req;
    assign ibus_addr_o = addr_q;
    assign pc_o        = pc_q;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for the fetch stage: zero-wait streaming, wait states,
// redirect during an outstanding fetch, stall with skid capture, jump/hold
// collision, PC wrap and asynchronous reset.
module tb_ifetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        hold_flag;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_ack;
    logic [31:0] ibus_rdata;
    logic [31:0] ins;
    logic [31:0] ins_addr;
    logic        ins_valid;
    logic [31:0] pc;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    ifetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .jump_en_i   (jump_en),
        .jump_addr_i (jump_addr),
        .hold_flag_i (hold_flag),
        .ibus_req_o  (ibus_req),
        .ibus_addr_o (ibus_addr),
        .ibus_ack_i  (ibus_ack),
        .ibus_rdata_i(ibus_rdata),
        .ins_o       (ins),
        .ins_addr_o  (ins_addr),
        .ins_valid_o (ins_valid),
        .pc_o        (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins_of(input logic [31:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_bus(input string tag, input logic r, input logic [31:0] a);
        chk({tag, ".req"}, {31'd0, ibus_req}, {31'd0, r});
        chk({tag, ".addr"}, ibus_addr, a);
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] i, input logic [31:0] a, input logic v);
        chk({tag, ".ins"}, ins, i);
        chk({tag, ".ins_addr"}, ins_addr, a);
        chk({tag, ".valid"}, {31'd0, ins_valid}, {31'd0, v});
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Drive all inputs for the coming edge and let combinational outputs settle.
    task automatic set_in(input logic a, input logic [31:0] d, input logic h,
                          input logic j, input logic [31:0] ja);
        ibus_ack   = a;
        ibus_rdata = d;
        hold_flag  = h;
        jump_en    = j;
        jump_addr  = ja;
        #1;
    endtask

    // Leaves the DUT in S_IDLE, just after reset release.
    task automatic do_reset();
        rst = 1'b1;
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        // ---------------- reset values
        rst = 1'b1;
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc();
        cyc();
        chk_bus("rst", 1'b0, 32'h0);
        chk("rst.pc", pc, 32'h0);
        chk_ifid("rst", NOP, 32'h0, 1'b0);

        // ---------------- 1: zero-wait streaming, stray ack in IDLE ignored
        rst = 1'b0;
        set_in(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'd0);
        chk_bus("t1.idle", 1'b0, 32'h0);
        cyc();
        chk_ifid("t1.idle_ack", NOP, 32'h0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, ins_of(32'(4 * k)), 1'b0, 1'b0, 32'd0);
            chk_bus("t1.fetch", 1'b1, 32'(4 * k));
            if (k > 0) chk_ifid("t1.ifid", ins_of(32'(4 * (k - 1))), 32'(4 * (k - 1)), 1'b1);
            cyc();
        end
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk_ifid("t1.last", ins_of(32'hC), 32'hC, 1'b1);
        chk_bus("t1.next", 1'b1, 32'h10);
        chk("t1.pc", pc, 32'h10);

        // ---------------- 2: three wait cycles on the fetch of 0x8
        do_reset();
        cyc();
        set_in(1'b1, ins_of(32'h0), 1'b0, 1'b0, 32'd0);
        cyc();
        set_in(1'b1, ins_of(32'h4), 1'b0, 1'b0, 32'd0);
        cyc();
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk_ifid("t2.pre", ins_of(32'h4), 32'h4, 1'b1);
        for (int w = 0; w < 3; w++) begin
            chk_bus("t2.wait", 1'b1, 32'h8);
            cyc();
            set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
            chk("t2.bubble", {31'd0, ins_valid}, 32'd0);
        end
        set_in(1'b1, ins_of(32'h8), 1'b0, 1'b0, 32'd0);
        chk_bus("t2.ackcyc", 1'b1, 32'h8);
        cyc();
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk_ifid("t2.load", ins_of(32'h8), 32'h8, 1'b1);
        chk_bus("t2.next", 1'b1, 32'hC);
        cyc();
        chk("t2.once", {31'd0, ins_valid}, 32'd0);

        // ---------------- 3: jump to 0x103 while fetch of 0x10 is outstanding
        do_reset();
        cyc();
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, ins_of(32'(4 * k)), 1'b0, 1'b0, 32'd0);
            cyc();
        end
        set_in(1'b0, 32'd0, 1'b0, 1'b1, 32'h0000_0103);
        chk_bus("t3.pend", 1'b1, 32'h10);
        cyc();
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk_bus("t3.disc", 1'b1, 32'h10);
        chk("t3.pc", pc, 32'h100);
        chk_ifid("t3.flush", NOP, 32'hC, 1'b0);
        cyc();
        set_in(1'b1, ins_of(32'h10), 1'b0, 1'b0, 32'd0);
        chk_bus("t3.disc2", 1'b1, 32'h10);
        cyc();
        set_in(1'b1, ins_of(32'h100), 1'b0, 1'b0, 32'd0);
        chk_bus("t3.target", 1'b1, 32'h100);
        chk("t3.drop", {31'd0, ins_valid}, 32'd0);
        cyc();
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk_ifid("t3.tgt_ins", ins_of(32'h100), 32'h100, 1'b1);
        chk_bus("t3.after", 1'b1, 32'h104);

        // ---------------- 4a: hold over a waiting fetch, ack lands mid-hold
        do_reset();
        cyc();
        set_in(1'b1, ins_of(32'h0), 1'b0, 1'b0, 32'd0);
        cyc();
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc();
        set_in(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk_bus("t4.hold_pend", 1'b1, 32'h4);
        cyc();
        set_in(1'b1, ins_of(32'h4), 1'b1, 1'b0, 32'd0);
        chk_bus("t4.hold_ack", 1'b1, 32'h4);
        cyc();
        set_in(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        chk("t4.stall_req", {31'd0, ibus_req}, 32'd0);
        chk("t4.stall_pc", pc, 32'h8);
        chk_ifid("t4.frozen", NOP, 32'h0, 1'b0);
        cyc();
        set_in(1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
        cyc();
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk("t4.frozen2", {31'd0, ins_valid}, 32'd0);
        cyc();
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk_ifid("t4.release", ins_of(32'h4), 32'h4, 1'b1);
        chk_bus("t4.next", 1'b1, 32'h8);
        cyc();
        chk("t4.consumed", {31'd0, ins_valid}, 32'd0);

        // ---------------- 4b: hold at request start, IF/ID frozen, no lost fetch
        do_reset();
        cyc();
        set_in(1'b1, ins_of(32'h0), 1'b0, 1'b0, 32'd0);
        cyc();
        set_in(1'b1, ins_of(32'h4), 1'b1, 1'b0, 32'd0);
        chk("t4b.noreq", {31'd0, ibus_req}, 32'd0);
        cyc();
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk_ifid("t4b.frozen", ins_of(32'h0), 32'h0, 1'b1);
        chk("t4b.pc", pc, 32'h4);
        cyc();
        chk_bus("t4b.refetch", 1'b1, 32'h4);
        chk("t4b.consumed", {31'd0, ins_valid}, 32'd0);

        // ---------------- 5: jump + hold + ack together
        do_reset();
        cyc();
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        cyc();
        set_in(1'b1, ins_of(32'h0), 1'b1, 1'b1, 32'h0000_0201);
        chk_bus("t5.pend", 1'b1, 32'h0);
        cyc();
        set_in(1'b1, ins_of(32'h200), 1'b0, 1'b0, 32'd0);
        chk_bus("t5.target", 1'b1, 32'h200);
        chk_ifid("t5.dropped", NOP, 32'h0, 1'b0);
        cyc();
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk_ifid("t5.tgt_ins", ins_of(32'h200), 32'h200, 1'b1);

        // ---------------- 6: PC wrap, then async reset mid-wait
        do_reset();
        cyc();
        set_in(1'b1, ins_of(32'h0), 1'b0, 1'b1, 32'hFFFF_FFFF);
        cyc();
        set_in(1'b1, 32'h1234_5678, 1'b0, 1'b0, 32'd0);
        chk_bus("t6.top", 1'b1, 32'hFFFF_FFFC);
        cyc();
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk_bus("t6.wrap", 1'b1, 32'h0);
        chk_ifid("t6.ins", 32'h1234_5678, 32'hFFFF_FFFC, 1'b1);
        rst = 1'b1;
        #1;
        chk_bus("t6.async", 1'b0, 32'h0);
        chk_ifid("t6.async", NOP, 32'h0, 1'b0);
        cyc();
        rst = 1'b0;
        set_in(1'b1, 32'hBAD0_0000, 1'b0, 1'b0, 32'd0);
        chk_bus("t6.idle", 1'b0, 32'h0);
        cyc();
        set_in(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        chk_bus("t6.refetch", 1'b1, 32'h0);
        chk("t6.late_ack", {31'd0, ins_valid}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
